// File: rtl/hack_memory_pkg.sv
// hack_mem_pkg: shared address map constants and scanner state type
package hack_mem_pkg;
  localparam int RAM_WORDS = 16384;
  localparam int SCREEN_WORDS = 8192;
  localparam logic [14:0] SCREEN_BASE = 15'h4000;
  localparam logic [14:0] KBD_ADDR = 15'h6000;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} scan_state_t;
endpackage

// File: rtl/hack_memory_if.sv
// hack_memory_if: CPU data bus, keyboard events and pixel stream
interface hack_memory_if;
  logic [14:0] addressM;
  logic writeM;
  logic [15:0] outM;
  logic [15:0] inM;
  logic kbd_valid;
  logic [15:0] kbd_code;
  logic pix_valid;
  logic pix_ready;
  logic pix_data;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic pix_sol;
  logic pix_sof;
  modport master(output addressM, writeM, outM, kbd_valid, kbd_code, pix_ready,
                 input inM, pix_valid, pix_data, pix_x, pix_y, pix_sol, pix_sof);
  modport slave(input addressM, writeM, outM, kbd_valid, kbd_code, pix_ready,
                output inM, pix_valid, pix_data, pix_x, pix_y, pix_sol, pix_sof);
endinterface

// File: rtl/hack_memory_screen_scan.sv
// hack_screen_scan: walks the screen map and streams it out one pixel per accept
module hack_screen_scan
  import hack_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [12:0] rd_addr_o,
  input  logic [15:0] rd_data_i,
  input  logic        pix_ready_i,
  output logic        pix_valid_o,
  output logic        pix_data_o,
  output logic [8:0]  pix_x_o,
  output logic [7:0]  pix_y_o,
  output logic        pix_sol_o,
  output logic        pix_sof_o
);
  scan_state_t state_q, state_d;
  logic [8:0] x_q;
  logic [7:0] y_q;
  logic [3:0] bit_q;
  logic [15:0] sh_q;
  logic acc;
  assign acc = (state_q == SHIFT) && pix_ready_i;
  assign rd_addr_o = {y_q, x_q[8:4]};
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  // next state: one fetch cycle per 16 accepted pixels
  always_comb
    state_d = state_q == IDLE  ? FETCH :
              state_q == FETCH ? SHIFT :
              (acc && bit_q == 4'd15) ? FETCH : SHIFT;
  // outputs; position registers only move on accept, so stalls hold them
  always_comb begin
    pix_valid_o = state_q == SHIFT;
    pix_data_o = pix_valid_o & sh_q[bit_q];
    pix_x_o = x_q;
    pix_y_o = y_q;
    pix_sol_o = pix_valid_o && x_q == 9'd0;
    pix_sof_o = pix_sol_o && y_q == 8'd0;
  end
  // counters and word buffer; the fetch samples memory before any same-edge write
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
    end else if (state_q == FETCH) begin
      sh_q <= rd_data_i;
      bit_q <= '0;
    end else if (acc) begin
      x_q <= x_q + 9'd1;
      bit_q <= bit_q + 4'd1;
      y_q <= y_q + 8'(x_q == 9'd511);
    end
endmodule

// File: rtl/hack_memory.sv
// hack_memory: Hack data memory with RAM, screen map, keyboard and screen scanner
module hack_memory
  import hack_mem_pkg::*;
(
  input logic clk,
  input logic reset,
  hack_memory_if.slave bus
);
  logic [15:0] ram [RAM_WORDS];
  logic [15:0] scr [SCREEN_WORDS];
  logic [15:0] kbd_q, kbd_d;
  logic [12:0] scan_addr;
  logic [15:0] scan_data;
  logic is_ram, is_scr, is_kbd;
  assign is_ram = bus.addressM < SCREEN_BASE;
  assign is_scr = bus.addressM >= SCREEN_BASE && bus.addressM < KBD_ADDR;
  assign is_kbd = bus.addressM == KBD_ADDR;
  assign scan_data = scr[scan_addr];
  // CPU read mux, unmapped reads return zero
  always_comb
    bus.inM = is_ram ? ram[bus.addressM[13:0]] :
              is_scr ? scr[bus.addressM[12:0]] :
              is_kbd ? kbd_q : 16'h0000;
  // CPU writes land in RAM or screen only; contents survive reset
  always_ff @(posedge clk) begin
    if (bus.writeM && is_ram) ram[bus.addressM[13:0]] <= bus.outM;
    if (bus.writeM && is_scr) scr[bus.addressM[12:0]] <= bus.outM;
  end
  // keyboard next value: only key events change it
  always_comb kbd_d = bus.kbd_valid ? bus.kbd_code : kbd_q;
  // keyboard register
  always_ff @(posedge clk or negedge reset)
    if (!reset) kbd_q <= '0;
    else kbd_q <= kbd_d;
  hack_screen_scan u_scan (
    .clk        (clk),
    .reset      (reset),
    .rd_addr_o  (scan_addr),
    .rd_data_i  (scan_data),
    .pix_ready_i(bus.pix_ready),
    .pix_valid_o(bus.pix_valid),
    .pix_data_o (bus.pix_data),
    .pix_x_o    (bus.pix_x),
    .pix_y_o    (bus.pix_y),
    .pix_sol_o  (bus.pix_sol),
    .pix_sof_o  (bus.pix_sof)
  );
endmodule

// File: doc/hack_memory.md
# hack_memory

Data-memory responder at the far end of the Hack CPU memory interface. Decodes the CPU's `addressM`/`writeM`/`outM` into 16K words of RAM, the 8K-word screen map and the keyboard register, and returns read data on `inM`. Also hosts the screen scanner, which streams the screen map as a pixel stream over a valid/ready interface to the display sink.

## Interface
- `RAM_WORDS`, 16384: general RAM depth, at 0x0000–0x3FFF.
- `SCREEN_BASE`, 15'h4000: first screen word; 8192 words, 512×256 pixels.
- `KBD_ADDR`, 15'h6000: keyboard register address.
- `clk` in 1: the single clock for all logic.
- `reset` in 1: asynchronous, active-low reset.
- `addressM` in 15: CPU word address.
- `writeM` in 1: CPU write strobe.
- `outM` in 16: CPU write data.
- `inM` out 16: read data for `addressM`.
- `kbd_valid` in 1: one-cycle keyboard event strobe.
- `kbd_code` in 16: key code; 0 means release.
- `pix_valid` out 1: `pix_data` is valid this cycle.
- `pix_ready` in 1: sink accepts the pixel.
- `pix_data` out 1: pixel, 1 = black.
- `pix_x` out 9: column 0–511 of the current pixel.
- `pix_y` out 8: row 0–255 of the current pixel.
- `pix_sol` out 1: `pix_x`==0.
- `pix_sof` out 1: `pix_x`==0 and `pix_y`==0.

## Operation
- Address decode:
  - `addressM` < 0x4000 → RAM.
  - 0x4000–0x5FFF → screen.
  - ==0x6000 → keyboard.
  - Anything above → unmapped.
- CPU reads are combinational: `inM` follows `addressM` in the same cycle. Unmapped addresses read 0.
- CPU writes commit on posedge `clk` when `writeM`=1, to RAM or screen only. Writes to the keyboard or to unmapped addresses are ignored.
- Keyboard register:
  - Loads `kbd_code` on posedge when `kbd_valid`=1 and otherwise holds.
  - A release event loads 0.
  - CPU writes never alter it.
- Screen scanner state machine:
  - **IDLE**: the reset state. Goes to FETCH on the first clock after reset deasserts.
  - **FETCH**: reads screen word `SCREEN_BASE + y*32 + x[8:4]` through a dedicated second read port into a 16-bit shift register. Sets `bit`=0 and goes to SHIFT.
  - **SHIFT**: drives `pix_valid`=1 and `pix_data` = word[`bit`], LSB = leftmost pixel. On `pix_valid & pix_ready`: `x`++ and `bit`++. When `bit`==15 is accepted, go to FETCH.
  - **Wrap**: `x` wraps 511→0 with `y`++; `y` wraps 255→0, which starts a new frame.
- The scanner holds `pix_data`, `pix_x` and `pix_y` stable while `pix_valid & ~pix_ready`.
- Width rules:
  - `x`, `y` and `bit` are modular counters.
  - Screen index = {`y`,`x[8:4]`}, 13 bits.

## Timing
- Reset values:
  - `pix_valid`=0, `pix_data`=0, `pix_x`=0, `pix_y`=0, `pix_sol`=0, `pix_sof`=0.
  - Keyboard register = 0; `inM` reads 0 for `KBD_ADDR`.
  - RAM and screen contents are not cleared.
- After reset release:
  - Cycle 1: IDLE→FETCH.
  - Cycle 2: FETCH→SHIFT.
  - `pix_valid` first rises in cycle 3, with `pix_sof`=1.
- Throughput: 16 pixels per 17 cycles under constant `pix_ready`. `pix_valid` drops for exactly one cycle per word, during FETCH.
- CPU write latency: a written value is visible on `inM` from the cycle after the write edge.
- CPU write to the screen word being fetched in the same cycle: the scanner captures the old value (read-before-write). A word written after its fetch appears only in the next frame.
- Keyboard event and CPU read of `KBD_ADDR` in the same cycle: the read returns the old value; the new value is visible next cycle.
- `reset` asserted mid-frame or mid-word: the scanner returns to IDLE asynchronously and `pix_valid` drops immediately. The frame restarts at (0,0).

## Structure
- Package `hack_mem_pkg`:
  - Address constants `SCREEN_BASE`, `KBD_ADDR` and `SCREEN_WORDS`=8192.
  - `scan_state_t` enum {IDLE, FETCH, SHIFT}.
- Sub-module `hack_screen_scan`: the scanner state machine, counters and shift register. It has a 13-bit read address out and 16-bit read data in.
- The top level holds RAM, screen memory (one write port, two read ports), the keyboard register and the decode logic.

## Test plan
- Write 0x1234 to 0x0005, then read 0x0005 → `inM`=0x1234 the next cycle. Read 0x7000 → `inM`=0.
- Write 0xFFFF to 0x6000 with no keyboard events → `inM`@0x6000 stays 0. Then `kbd_valid` with code 0x0041 → 0x0041. Then code 0 → 0.
- Write 0x0001 to 0x4000, hold `pix_ready`=1 after reset:
  - First pixel: (0,0), `pix_data`=1, `pix_sof`=1.
  - Pixels 1–15 read 0.
  - `pix_valid` is low in the cycle before pixel (16,0).
- Write 0x8000 to 0x401F (row 0, column 511) → the pixel at (511,0) is 1. The next accepted pixel is (0,1) with `pix_sol`=1 and `pix_sof`=0.
- Toggle `pix_ready` 1/0 every cycle → no pixel is skipped or duplicated. `pix_x` sequence 0,1,2,… with stable outputs during stalls.
- Assert `reset` at (200,100) mid-word → `pix_valid`=0 at once. After release, the first pixel is (0,0) with `pix_sof`=1.
